// File: rtl/key_expansion.sv
// Iterative AES-128 key schedule: accepts one cipher key and produces one round key per
// clock, holding all 11 round keys on a flat bus until the next key is accepted.
module key_expansion (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          IN_valid,
    input  logic [127:0]  IN_key,
    output logic          IN_ready,
    output logic          busy,
    output logic          OUT_valid,
    output logic          OUT_done,
    output logic [1407:0] OUT_keys
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        READY  = 2'b01,
        EXPAND = 2'b10
    } state_t;

    // FIPS-197 S-box, entry 0 in the most significant byte
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{~b, 3'b111} -: 8];
    endfunction

    state_t       state, state_n;
    logic [3:0]   rnd;
    logic [127:0] key_q [11];
    logic [127:0] prev_key, next_key;
    logic [31:0]  w0, w1, w2, w3, rot, t, n0, n1, n2, n3;
    logic [7:0]   rcon;
    logic         accept, last_step;

    assign busy      = (state == EXPAND);
    assign OUT_valid = (state == READY);
    assign IN_ready  = !busy;
    assign accept    = IN_valid && IN_ready;
    assign last_step = busy && (rnd == 4'd10);

    always_comb begin
        prev_key = '0;
        for (int unsigned i = 0; i < 10; i++) begin
            if (rnd == 4'(i + 1)) prev_key = key_q[i];
        end
    end

    always_comb begin
        rcon = 8'h00;
        case (rnd)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign {w0, w1, w2, w3} = prev_key;
    assign rot      = {w3[23:0], w3[31:24]};
    assign t        = {sbox(rot[31:24]) ^ rcon, sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    assign n0       = w0 ^ t;
    assign n1       = w1 ^ n0;
    assign n2       = w2 ^ n1;
    assign n3       = w3 ^ n2;
    assign next_key = {n0, n1, n2, n3};

    always_comb begin
        state_n = state;
        case (state)
            IDLE, READY: if (accept) state_n = EXPAND;
            EXPAND:      if (rnd == 4'd10) state_n = READY;
            default:     state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rnd      <= '0;
            OUT_done <= 1'b0;
            for (int unsigned i = 0; i < 11; i++) key_q[i] <= '0;
        end else begin
            OUT_done <= last_step;
            if (accept) begin
                key_q[0] <= IN_key;
                rnd      <= 4'd1;
            end else if (busy) begin
                for (int unsigned i = 1; i < 11; i++) begin
                    if (rnd == 4'(i)) key_q[i] <= next_key;
                end
                rnd <= last_step ? 4'd0 : rnd + 4'd1;
            end
        end
    end

    always_comb begin
        OUT_keys = '0;
        for (int unsigned i = 0; i < 11; i++) OUT_keys[128*i +: 128] = key_q[i];
    end

endmodule

// File: doc/key_expansion.md
# key_expansion

Iterative AES-128 key schedule that supplies the `RoundKey` inputs of the round pipeline. It accepts one 128-bit cipher key through a valid/ready handshake and expands it into the 11 round keys (round 0 … round 10), computing one round key per clock. It holds all 11 round keys stable on a flat output bus until the next key is accepted, so each round stage taps its own slice.

## Interface
- Parameters: none; AES-128 only (Nk=4, Nr=10, fixed).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `IN_valid`  in  1  `IN_key` is valid this cycle.
- `IN_key`  in  128  cipher key; byte 0 (first FIPS-197 byte) is `[127:120]`.
- `IN_ready`  out  1  block can accept a key; equals `!busy`.
- `busy`  out  1  expansion in progress.
- `OUT_valid`  out  1  all 11 round keys on `OUT_keys` are valid.
- `OUT_done`  out  1  one-cycle pulse when expansion completes.
- `OUT_keys`  out  1408  round key r at `[128*r+127 : 128*r]`, r = 0..10; same byte order as `IN_key`.

## Operation
- Storage: 11×128-bit key registers, a 4-bit round counter `rnd`, and the `busy`, `OUT_valid` and `OUT_done` flops.
- The Rcon byte is derived combinationally from `rnd`: 01,02,04,08,10,20,40,80,1B,36 for rnd = 1..10.
- SubWord is 4 combinational FIPS-197 S-box lookups; there are no other arithmetic units.
- States (encoded by `busy`/`OUT_valid`):
  - IDLE: `busy`=0, `OUT_valid`=0.
  - EXPAND: `busy`=1.
  - READY: `busy`=0, `OUT_valid`=1.
- Accept, when `IN_valid && IN_ready` at an edge:
  - key[0] ← `IN_key`, `rnd` ← 1, `busy` ← 1, `OUT_valid` ← 0.
  - Allowed from IDLE or READY. A new key overwrites the old set and `OUT_valid` drops.
- EXPAND step, at each edge, with prev = key[rnd-1] split into words w0..w3 (w0 = `[127:96]`):
  - t = SubWord(RotWord(w3)) ^ {Rcon, 24'h0}.
  - n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2.
  - key[rnd] ← {n0,n1,n2,n3}; `rnd` ← `rnd`+1.
- When rnd = 10, the step writes key[10] and then:
  - `busy` ← 0, `OUT_valid` ← 1, `OUT_done` ← 1 for exactly one cycle.
  - `rnd` ← 0 (held there while not busy).
- `IN_valid` while `busy`=1 is ignored: no abort, no queueing. Upstream must hold `IN_valid` until `IN_ready` is seen.
- Key registers not yet rewritten during EXPAND are don't-care. Consumers must qualify them with `OUT_valid`.
- `OUT_keys` must not change while `OUT_valid`=1, except at the acceptance edge of a new key.

## Timing
- Reset (asynchronous assert, any state, including mid-expansion):
  - `busy`=0, `OUT_valid`=0, `OUT_done`=0, `rnd`=0, all key registers 0.
  - `IN_ready`=1 and `OUT_keys`=0 during reset.
  - Release is synchronous to `clk`. The first acceptance can happen at the first edge after `reset_n` rises.
- Acceptance at edge E0 writes key[0]; edges E1..E10 write key[1]..key[10].
- `OUT_valid` and `OUT_done` are high after E10, i.e. 10 cycles after acceptance.
- `IN_ready` is low from after E0 until after E10. Back-to-back keys are therefore accepted at most every 11 cycles; a key presented in the READY cycle is accepted at E11.
- `OUT_done` and a new acceptance may coincide: `OUT_valid` is high for that one cycle only, then cleared.
- Throughput: one expanded key set per 11 cycles.

## Test plan
- FIPS-197 A.1 vector: accept 2b7e151628aed2a6abf7158809cf4f3c.
  - Round 1 = a0fafe1788542cb123a339392a6c7605.
  - Round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - `OUT_done` is high exactly 10 cycles after acceptance.
- All-zero key:
  - Round 1 = 62636363626363636263636362636363.
  - Round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Busy rejection: assert `IN_valid` with a second key at cycles 3..9 of an expansion.
  - Result stays that of the first key; `IN_ready`=0 throughout.
  - The second key is accepted only after `OUT_done`.
- Back-to-back: hold `IN_valid` continuously with key A then key B.
  - B is accepted at E11; `OUT_valid` is high for one cycle with A's set.
  - B's set is correct 10 cycles later.
- Reset mid-expansion: drop `reset_n` at round 5.
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - After release, a fresh A.1 key expands correctly.
- Stability: in READY, toggle `IN_valid`=0 for 50 cycles.
  - `OUT_keys` and `OUT_valid` stay unchanged; `OUT_done` stays 0.
